// File: rtl/regblock_ctrl.sv
// Register-transfer controller: accepts one opcode at a time and sequences its source selects, memory fetch and write-back.
// Latency: write-back 2 cycles after accept (memory ops add one MEM cycle per wait); instr_ready is high only in IDLE.
module regblock_ctrl #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [3:0] opcode,
  output logic       instr_ready,
  input  logic       abort,
  output logic       mem_req,
  input  logic       mem_ack,
  output logic       mary_write,
  output logic       shelley_write,
  output logic       comp_write,
  output logic       ra_write,
  output logic [1:0] mary_src,
  output logic [1:0] shelley_src,
  output logic       ra_src,
  output logic       done,
  output logic       err
);
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, DECODE, MEM, WB} state_t;

  state_t        state_q, state_d;
  logic [3:0]    opcode_q, opcode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    wr_q, wr_d;
  logic          mem_req_q, mem_req_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    mary_src_q, mary_src_d;
  logic [1:0]    shelley_src_q, shelley_src_d;
  logic          ra_src_q, ra_src_d;

  // Write enable vector for an opcode, ordered {mary, shelley, comp, ra}.
  function automatic logic [3:0] wr_sel(input logic [3:0] op);
    case (op)
      4'd0, 4'd2, 4'd4, 4'd6: wr_sel = 4'b1000;
      4'd1, 4'd3, 4'd7:       wr_sel = 4'b0100;
      4'd5:                   wr_sel = 4'b0010;
      4'd8, 4'd9:             wr_sel = 4'b0001;
      default:                wr_sel = 4'b0000;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    cnt_d         = cnt_q;
    wr_d          = 4'b0000;
    mem_req_d     = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    mary_src_d    = mary_src_q;
    shelley_src_d = shelley_src_q;
    ra_src_d      = ra_src_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          opcode_d = opcode;
          state_d  = DECODE;
          // Selects are loaded at accept so they are already valid during DECODE.
          case (opcode)
            4'd0:    mary_src_d    = 2'b00;
            4'd2:    mary_src_d    = 2'b11;
            4'd4:    mary_src_d    = 2'b01;
            4'd6:    mary_src_d    = 2'b10;
            4'd1:    shelley_src_d = 2'b00;
            4'd3:    shelley_src_d = 2'b01;
            4'd7:    shelley_src_d = 2'b10;
            4'd8:    ra_src_d      = 1'b1;
            4'd9:    ra_src_d      = 1'b0;
            default: ;
          endcase
        end
      end
      DECODE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (opcode_q == 4'd0 || opcode_q == 4'd1 || opcode_q == 4'd9) begin
          state_d   = MEM;
          cnt_d     = '0;
          mem_req_d = 1'b1;
        end else if (opcode_q <= 4'd8) begin
          state_d = WB;
          wr_d    = wr_sel(opcode_q);
          done_d  = 1'b1;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      MEM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          state_d = WB;
          wr_d    = wr_sel(opcode_q);
          done_d  = 1'b1;
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          mem_req_d = 1'b1;
        end
      end
      WB: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      opcode_q      <= 4'd0;
      cnt_q         <= '0;
      wr_q          <= 4'b0000;
      mem_req_q     <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      mary_src_q    <= 2'b00;
      shelley_src_q <= 2'b00;
      ra_src_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      mem_req_q     <= mem_req_d;
      done_q        <= done_d;
      err_q         <= err_d;
      mary_src_q    <= mary_src_d;
      shelley_src_q <= shelley_src_d;
      ra_src_q      <= ra_src_d;
    end
  end

  assign instr_ready   = (state_q == IDLE);
  assign mem_req       = mem_req_q;
  assign mary_write    = wr_q[3];
  assign shelley_write = wr_q[2];
  assign comp_write    = wr_q[1];
  assign ra_write      = wr_q[0];
  assign done          = done_q;
  assign err           = err_q;
  assign mary_src      = mary_src_q;
  assign shelley_src   = shelley_src_q;
  assign ra_src        = ra_src_q;
endmodule

// File: tb/tb_regblock_ctrl.sv
// Bench for regblock_ctrl: per-instruction timeline model derived from the opcode map, latencies and abort/timeout rules.
module tb_regblock_ctrl;
  localparam int T = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       abort = 1'b0;
  logic       mem_ack = 1'b0;
  logic       instr_ready, mem_req, mary_write, shelley_write, comp_write, ra_write;
  logic [1:0] mary_src, shelley_src;
  logic       ra_src, done, err;

  int checks = 0;
  int errors = 0;

  // Expected select values, updated when a legal opcode is accepted.
  logic [1:0] m_mary = 2'b00;
  logic [1:0] m_shel = 2'b00;
  logic       m_ra   = 1'b0;

  regblock_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready), .abort(abort), .mem_req(mem_req), .mem_ack(mem_ack),
    .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write),
    .ra_write(ra_write), .mary_src(mary_src), .shelley_src(shelley_src),
    .ra_src(ra_src), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] observed();
    return {instr_ready, mem_req, mary_write, shelley_write, comp_write, ra_write,
            done, err, mary_src, shelley_src, ra_src};
  endfunction

  function automatic logic [3:0] write_of(input int op);
    if (op == 0 || op == 2 || op == 4 || op == 6) return 4'b1000;
    if (op == 1 || op == 3 || op == 7) return 4'b0100;
    if (op == 5) return 4'b0010;
    if (op == 8 || op == 9) return 4'b0001;
    return 4'b0000;
  endfunction

  // Starts at a negedge in IDLE; ends at the negedge where instr_ready is expected back.
  // ack_idx: MEM cycle (0-based) carrying mem_ack, -1 for none; abort_off: cycle after accept (1 = DECODE) with abort, -1 for none.
  task automatic run_instr(input int op, input int ack_idx, input int abort_off);
    bit is_mem = (op == 0 || op == 1 || op == 9);
    bit legal  = (op <= 9);
    int mem_lo = -1, mem_hi = -2, wb_t = -1, err_t = -1, rdy_t, last_act;
    logic [12:0] exp_v, got_v;
    bit wb;
    if (!legal) begin
      err_t = 2; rdy_t = 2; last_act = 1;
    end else if (!is_mem) begin
      wb_t = 2; rdy_t = 3; last_act = 1;
    end else if (ack_idx >= 0 && ack_idx < T) begin
      mem_lo = 2; mem_hi = 2 + ack_idx; wb_t = mem_hi + 1; rdy_t = wb_t + 1; last_act = mem_hi;
    end else begin
      mem_lo = 2; mem_hi = T + 1; err_t = T + 2; rdy_t = T + 2; last_act = mem_hi;
    end
    if (abort_off >= 1 && abort_off <= last_act) begin
      if (mem_hi > abort_off) mem_hi = abort_off;
      wb_t = -1; err_t = -1; rdy_t = abort_off + 1;
    end
    instr_valid = 1'b1;
    opcode      = 4'(op);
    abort       = 1'($urandom_range(0, 1));
    mem_ack     = 1'($urandom_range(0, 1));
    case (op)
      0: m_mary = 2'b00;  2: m_mary = 2'b11;  4: m_mary = 2'b01;  6: m_mary = 2'b10;
      1: m_shel = 2'b00;  3: m_shel = 2'b01;  7: m_shel = 2'b10;
      8: m_ra = 1'b1;     9: m_ra = 1'b0;
      default: ;
    endcase
    for (int t = 1; t <= rdy_t; t++) begin
      @(negedge clock);
      wb    = (t == wb_t);
      exp_v = {t == rdy_t, (t >= mem_lo && t <= mem_hi), (wb ? write_of(op) : 4'b0000),
               wb, t == err_t, m_mary, m_shel, m_ra};
      got_v = observed();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL instr op=%0d ack=%0d abort=%0d cycle=%0d: got %b required %b",
                 op, ack_idx, abort_off, t, got_v, exp_v);
      end
      instr_valid = 1'b0;
      abort       = (t == abort_off);
      mem_ack     = 1'b0;
      if (is_mem && t == 2 + ack_idx) mem_ack = 1'b1;
      else if (t == 1 || t == wb_t) mem_ack = 1'($urandom_range(0, 1));
      if (t == rdy_t) begin
        abort = 1'b0; mem_ack = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [12:0] got_v;
    reset = 1'b1; instr_valid = 1'b1; opcode = 4'd2;
    @(negedge clock);
    got_v = observed();
    checks++;
    if (got_v !== 13'b1_0_0000_0_0_00_00_0) begin
      errors++; $display("FAIL reset_vals: got %b required %b", got_v, 13'b1000000000000);
    end
    @(negedge clock);
    got_v = observed();
    checks++;
    if (got_v !== 13'b1_0_0000_0_0_00_00_0) begin
      errors++; $display("FAIL reset_hold: got %b required %b", got_v, 13'b1000000000000);
    end
    instr_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_instr(2, -1, -1);   // mary<-imm timing
    run_instr(9, 2, -1);    // ack on third MEM cycle
    run_instr(0, -1, -1);   // timeout
    run_instr(12, -1, -1);  // illegal, selects unchanged
    run_instr(1, 1, 3);     // abort together with ack
    run_instr(1, 0, -1);    // ack in first MEM cycle
    run_instr(0, T - 1, -1);// ack on last allowed MEM cycle
    run_instr(4, -1, 1);    // abort in DECODE
    run_instr(13, -1, 1);   // abort on illegal opcode suppresses err
    run_instr(0, -1, T + 1);// abort coincides with timeout cycle
    run_instr(5, -1, 2);    // abort in WB ignored
    run_instr(9, 3, 6);     // abort in WB after memory
  endtask

  task automatic test_back_to_back();
    for (int op = 0; op < 16; op++) run_instr(op, 0, -1);
  endtask

  task automatic test_random();
    int op, ack, ab;
    for (int n = 0; n < 200; n++) begin
      op  = $urandom_range(0, 15);
      ack = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, T);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, T + 3) : -1;
      run_instr(op, ack, ab);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          mem_ack = 1'($urandom_range(0, 1));
          abort   = 1'($urandom_range(0, 1));
          @(negedge clock);
          checks++;
          if (observed() !== {1'b1, 7'b0, m_mary, m_shel, m_ra}) begin
            errors++;
            $display("FAIL idle_hold: got %b required %b", observed(), {1'b1, 7'b0, m_mary, m_shel, m_ra});
          end
        end
        mem_ack = 1'b0; abort = 1'b0;
      end
    end
  endtask

  task automatic test_reset_in_wb();
    logic [12:0] got_v;
    instr_valid = 1'b1; opcode = 4'd5;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (comp_write !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL wb_before_reset: got comp_write=%b done=%b required 1 1", comp_write, done);
    end
    #2 reset = 1'b1;
    #1 got_v = observed();
    checks++;
    if (got_v !== 13'b1_0_0000_0_0_00_00_0) begin
      errors++; $display("FAIL async_reset_wb: got %b required %b", got_v, 13'b1000000000000);
    end
    m_mary = 2'b00; m_shel = 2'b00; m_ra = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    got_v = observed();
    checks++;
    if (got_v !== 13'b1_0_0000_0_0_00_00_0) begin
      errors++; $display("FAIL post_reset_idle: got %b required %b", got_v, 13'b1000000000000);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    run_instr(7, -1, -1);
    test_reset_in_wb();
    run_instr(6, -1, -1);
    run_instr(9, 0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regblock_ctrl.md
REGBLOCK_CTRL -- requirements
Module: regblock_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8: maximum cycles mem_req is held without mem_ack before the instruction aborts with error.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; returns the block to IDLE immediately.
REQ-004 instr_valid  input  1  requester presents an instruction.
REQ-005 opcode  input  4  register-transfer opcode, sampled on accept.
REQ-006 instr_ready  output  1  controller can accept; high only in IDLE.
REQ-007 abort  input  1  synchronous cancel of the in-flight instruction.
REQ-008 mem_req  output  1  memory read request for memval-sourced writes.
REQ-009 mem_ack  input  1  memval valid this cycle.
REQ-010 mary_write, shelley_write, comp_write, ra_write  output  1 each  register write enables.
REQ-011 mary_src  output  2  mary source: 00 memval, 01 aluout, 10 shelley, 11 immediate.
REQ-012 shelley_src  output  2  shelley source: 00 memval, 01 immediate, 10 mary.
REQ-013 ra_src  output  1  ra source: 0 memval, 1 pc+2.
REQ-014 done  output  1  one-cycle pulse; instruction retired with its write.
REQ-015 err  output  1  one-cycle pulse; illegal opcode or memory timeout.

Function
REQ-016 States SHALL be IDLE, DECODE, MEM, WB; encoding is free.
REQ-017 Accept SHALL occur when instr_valid and instr_ready are both high; opcode is latched and the next state is DECODE.
REQ-018 Opcode map SHALL be: 0 mary<-mem; 1 shelley<-mem; 2 mary<-imm; 3 shelley<-imm; 4 mary<-alu; 5 comp<-alu; 6 mary<-shelley; 7 shelley<-mary; 8 ra<-pc+2; 9 ra<-mem; 10-15 illegal.
REQ-019 In DECODE, src outputs SHALL be registered for the latched opcode and held until the next DECODE; for illegal opcodes the src outputs are unchanged.
REQ-020 DECODE SHALL go to MEM for opcodes 0, 1 and 9, to WB for opcodes 2-8, and to IDLE with an err pulse for opcodes 10-15.
REQ-021 In MEM, mem_req SHALL be high every cycle; mem_ack sampled high moves to WB next cycle; this includes an ack in the first MEM cycle.
REQ-022 The MEM cycle counter SHALL be 0 on entry; after MEM_TIMEOUT cycles without ack, the next state is IDLE with an err pulse and no write.
REQ-023 In WB, exactly one write enable (per REQ-018) and done SHALL be high for exactly one cycle, then the next state is IDLE.
REQ-024 Latency for non-memory ops: accept at edge N, DECODE in cycle N+1, WB with write and done in cycle N+2, instr_ready high in cycle N+3.
REQ-025 Latency for memory ops: mem_req first high in cycle N+2; WB occurs in the cycle after the first cycle mem_ack is sampled high.
REQ-026 abort in DECODE or MEM SHALL return the block to IDLE next cycle with no write, no done and no err; abort outweighs a simultaneous mem_ack or timeout.
REQ-027 abort in WB SHALL be ignored; the write and done complete.
REQ-028 abort in IDLE SHALL be ignored, and an instr_valid in that same cycle is still accepted.
REQ-029 Write enables, done, err and mem_req SHALL never be high outside the states named above.
REQ-030 mem_ack outside MEM SHALL be ignored.

Reset
REQ-031 While reset is high, the state SHALL be IDLE and outputs SHALL be: instr_ready=1; mem_req, all writes, done, err=0; mary_src=00; shelley_src=00; ra_src=0.
REQ-032 Reset asserted mid-instruction, including during WB, SHALL take effect without waiting for a clock edge and SHALL cancel any pending write.

Verification
REQ-033 Opcode 2 accepted at cycle 0 -> mary_src=11 from cycle 1; mary_write and done high in cycle 2 only; instr_ready high in cycle 3.
REQ-034 Opcode 9 with mem_ack on the 3rd MEM cycle -> mem_req high for 3 cycles; ra_src=0; ra_write and done in the next cycle.
REQ-035 Opcode 0 with no ack and MEM_TIMEOUT=8 -> mem_req high for 8 cycles, then an err pulse; mary_write is never high.
REQ-036 Opcode 12 -> err pulse in the DECODE-exit cycle; no write enables; src outputs keep their prior values.
REQ-037 Opcode 1 with abort and mem_ack in the same MEM cycle -> IDLE next cycle; shelley_write, done and err all stay 0.
REQ-038 Reset asserted asynchronously during WB of opcode 5 -> comp_write drops immediately; all outputs take their REQ-031 values.
